// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide sequencer owning the HI/LO registers
module mdu_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCTION_SIZE = 6,
    parameter int CNT_SIZE      = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [FUNCTION_SIZE-1:0] i_funct_code,
    input  logic [DATA_WIDTH-1:0]    i_data_a,
    input  logic [DATA_WIDTH-1:0]    i_data_b,
    input  logic                     i_flush,
    output logic [DATA_WIDTH-1:0]    o_hi,
    output logic [DATA_WIDTH-1:0]    o_lo,
    output logic [DATA_WIDTH-1:0]    o_read_data,
    output logic                     o_busy,
    output logic                     o_stall,
    output logic                     o_done
);

    localparam logic [FUNCTION_SIZE-1:0] F_MFHI  = FUNCTION_SIZE'(6'h10);
    localparam logic [FUNCTION_SIZE-1:0] F_MTHI  = FUNCTION_SIZE'(6'h11);
    localparam logic [FUNCTION_SIZE-1:0] F_MFLO  = FUNCTION_SIZE'(6'h12);
    localparam logic [FUNCTION_SIZE-1:0] F_MTLO  = FUNCTION_SIZE'(6'h13);
    localparam logic [FUNCTION_SIZE-1:0] F_MULT  = FUNCTION_SIZE'(6'h18);
    localparam logic [FUNCTION_SIZE-1:0] F_MULTU = FUNCTION_SIZE'(6'h19);
    localparam logic [FUNCTION_SIZE-1:0] F_DIV   = FUNCTION_SIZE'(6'h1A);
    localparam logic [FUNCTION_SIZE-1:0] F_DIVU  = FUNCTION_SIZE'(6'h1B);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              r_state;
    logic [CNT_SIZE-1:0] r_cnt;
    logic [2*W-1:0]      r_acc;
    logic [W-1:0]        r_opnd;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div_zero;
    logic                r_is_div;
    logic [W-1:0]        r_hi;
    logic [W-1:0]        r_lo;
    logic                r_done;

    logic           w_is_mdu;
    logic           w_signed_op;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_shift;
    logic [W:0]     w_div_diff;
    logic           w_div_ok;
    logic [2*W-1:0] w_div_next;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;

    always_comb begin
        w_is_mdu = 1'b0;
        case (i_funct_code)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: w_is_mdu = 1'b1;
            default:                        w_is_mdu = 1'b0;
        endcase
    end

    assign w_signed_op = (i_funct_code == F_MULT) || (i_funct_code == F_DIV);
    assign w_a_neg     = w_signed_op & i_data_a[W-1];
    assign w_b_neg     = w_signed_op & i_data_b[W-1];
    assign w_a_mag     = w_a_neg ? -i_data_a : i_data_a;
    assign w_b_mag     = w_b_neg ? -i_data_b : i_data_b;

    // Multiply: accumulate into the upper half, shift the multiplier out of the lower half
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
    assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ok    = ~w_div_diff[W];
    assign w_div_next  = {(w_div_ok ? w_div_diff[W-1:0] : w_div_shift[W-1:0]),
                          r_acc[W-2:0], w_div_ok};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_div_zero ? '1 : (r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0]);
    assign w_rem_fix  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_is_div   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        case (i_funct_code)
                            F_MULT, F_MULTU: begin
                                r_acc    <= {{W{1'b0}}, w_b_mag};
                                r_opnd   <= w_a_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= 1'b0;
                                r_is_div <= 1'b0;
                                r_cnt    <= CNT_SIZE'(W - 1);
                                r_state  <= S_MUL;
                            end
                            F_DIV, F_DIVU: begin
                                r_acc      <= {{W{1'b0}}, w_a_mag};
                                r_opnd     <= w_b_mag;
                                r_neg_q    <= w_a_neg ^ w_b_neg;
                                r_neg_r    <= w_a_neg;
                                r_div_zero <= (i_data_b == '0);
                                r_is_div   <= 1'b1;
                                r_cnt      <= CNT_SIZE'(W - 1);
                                r_state    <= S_DIV;
                            end
                            F_MTHI:  r_hi <= i_data_a;
                            F_MTLO:  r_lo <= i_data_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
                        if (r_cnt == '0) r_state <= S_FIX;
                        else             r_cnt   <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!i_flush) begin
                        r_hi   <= r_is_div ? w_rem_fix : w_prod_fix[2*W-1:W];
                        r_lo   <= r_is_div ? w_quo_fix : w_prod_fix[W-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_done  = r_done;
    assign o_busy  = (r_state != S_IDLE);
    assign o_stall = o_busy & i_start & w_is_mdu;
    assign o_read_data = !i_start                 ? '0   :
                         (i_funct_code == F_MFHI) ? r_hi :
                         (i_funct_code == F_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with directed vectors
module tb_mdu_ctrl;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [5:0]  i_funct_code = '0;
    logic [31:0] i_data_a = '0;
    logic [31:0] i_data_b = '0;
    logic        i_flush = 1'b0;
    logic [31:0] o_hi, o_lo, o_read_data;
    logic        o_busy, o_stall, o_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t exp_q[$];

    mdu_ctrl dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_funct_code (i_funct_code),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .i_flush      (i_flush),
        .o_hi         (o_hi),
        .o_lo         (o_lo),
        .o_read_data  (o_read_data),
        .o_busy       (o_busy),
        .o_stall      (o_stall),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest outstanding expectation
    always @(negedge i_clk) begin
        if (o_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hi"}, 64'(o_hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(o_lo), 64'(e.lo));
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1; i_funct_code = f; i_data_a = a; i_data_b = b;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        int busy_cnt = 0;
        logic seen = 1'b0;
        exp_t e;
        e.name = name; e.hi = hi; e.lo = lo;
        exp_q.push_back(e);
        issue(f, a, b);
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge i_clk);
            if (o_done) seen = 1'b1;
            else if (o_busy) busy_cnt++;
        end
        check({name, "_done_seen"}, 64'(seen), 1);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 33);
        @(posedge i_clk); #1;
        check({name, "_sb_empty"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        int bad, cnt;
        logic seen;
        logic [31:0] hold_hi, hold_lo;

        #2;
        check("rst_hi", 64'(o_hi), 0);
        check("rst_lo", 64'(o_lo), 0);
        check("rst_busy", 64'(o_busy), 0);
        check("rst_stall", 64'(o_stall), 0);
        check("rst_done", 64'(o_done), 0);
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        i_start = 1'b1; i_funct_code = F_MTLO; i_data_a = 32'h1234;
        @(negedge i_clk);
        check("mtlo_no_stall", 64'(o_stall), 0);
        @(posedge i_clk); #1;
        i_funct_code = F_MTHI; i_data_a = 32'hABCD;
        check("mtlo_lo", 64'(o_lo), 32'h1234);
        check("mtlo_busy", 64'(o_busy), 0);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("mthi_hi", 64'(o_hi), 32'hABCD);
        @(negedge i_clk);
        check("mt_no_done", 64'(o_done), 0);
        @(posedge i_clk); #1;

        run_op("mult_neg3x7", F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("divu_100_7",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_neg7_2",  F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_5_0",    F_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        run_op("div_neg5_0",  F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("mult_min_sq", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        // MFHI held in EX behind a MULT: stall every cycle until the done cycle
        begin
            exp_t e;
            e.name = "stall_mult"; e.hi = 32'h3; e.lo = 32'h0;
            exp_q.push_back(e);
        end
        i_start = 1'b1; i_funct_code = F_MULT; i_data_a = 32'h10000; i_data_b = 32'h30000;
        @(posedge i_clk); #1;
        i_funct_code = F_MFHI;
        bad = 0; cnt = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                check("stall_released", 64'(o_stall), 0);
                check("mfhi_new_hi", 64'(o_read_data), 32'h3);
            end else begin
                if (!o_stall) bad++;
                cnt++;
            end
        end
        check("stall_done_seen", 64'(seen), 1);
        check("stall_gaps", 64'(bad), 0);
        check("stall_cycles", 64'(cnt), 33);
        @(posedge i_clk); #1;
        i_start = 1'b0;

        // Flush mid-MULT; non-MDU code while busy must not stall
        hold_hi = 32'h3; hold_lo = 32'h0;
        issue(F_MULT, 32'd9, 32'd9);
        i_start = 1'b1; i_funct_code = 6'h20;
        @(negedge i_clk);
        check("nonmdu_no_stall", 64'(o_stall), 0);
        check("nonmdu_busy", 64'(o_busy), 1);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (8) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_still_busy", 64'(o_busy), 1);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush_idle", 64'(o_busy), 0);
        repeat (40) @(posedge i_clk);
        #1;
        check("flush_hi_kept", 64'(o_hi), 64'(hold_hi));
        check("flush_lo_kept", 64'(o_lo), 64'(hold_lo));

        i_flush = 1'b1;
        issue(F_MULT, 32'd2, 32'd3);
        i_flush = 1'b0;
        check("flush_blocks_accept", 64'(o_busy), 0);

        // Asynchronous reset in the middle of a DIV
        issue(F_DIV, 32'd100, 32'd7);
        repeat (19) @(posedge i_clk);
        #3 i_reset_n = 1'b0;
        #1;
        check("arst_hi", 64'(o_hi), 0);
        check("arst_lo", 64'(o_lo), 0);
        check("arst_busy", 64'(o_busy), 0);
        check("arst_done", 64'(o_done), 0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        run_op("divu_after_rst", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        repeat (3) @(posedge i_clk);
        check("final_sb_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for the EX-stage multiply/divide resource: MULT, MULTU, DIV, DIVU and the HI/LO moves MFHI, MFLO, MTHI, MTLO.
- Runs one iterative shift-add multiply or restoring divide over DATA_WIDTH cycles and owns the HI/LO registers.
- Raises a stall toward the hazard unit when a HI/LO-dependent instruction reaches EX while an operation is in flight.
- Sits beside the ALU and is fed from the same decoded function code and operands.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- FUNCTION_SIZE, 6, R-type function code width.
- CNT_SIZE, 6, iteration counter width; must satisfy 2^CNT_SIZE > DATA_WIDTH.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  EX holds a valid R-type instruction; qualifies i_funct_code.
- i_funct_code  in  FUNCTION_SIZE  function code. MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. All other codes are ignored.
- i_data_a  in  DATA_WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source).
- i_data_b  in  DATA_WIDTH  rt operand (multiplier / divisor).
- i_flush  in  1  aborts the in-flight operation.
- o_hi  out  DATA_WIDTH  HI register.
- o_lo  out  DATA_WIDTH  LO register.
- o_read_data  out  DATA_WIDTH  combinational: o_hi for MFHI, o_lo for MFLO, 0 otherwise.
- o_busy  out  1  state != IDLE.
- o_stall  out  1  freeze IF/ID/EX.
- o_done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV.

Behaviour:
- Reset (async, i_reset_n=0): state IDLE, counter 0, HI=LO=0, o_done=0, o_busy=0, o_stall=0, internal accumulators 0. Reset during an operation discards it.
- States: IDLE, MUL, DIV, FIX.
- IDLE, accepted MULT/MULTU/DIVU/DIV (i_start=1):
  - Latch operands. For the signed ops latch magnitudes and record the result signs.
  - Counter = DATA_WIDTH-1; go to MUL or DIV.
  - The accept edge is edge 0.
- IDLE, accepted MTHI/MTLO: HI or LO <= i_data_a at that edge; state stays IDLE; o_done stays 0.
- MUL: one shift-add step per edge on a 2*DATA_WIDTH product.
- DIV: one restoring step per edge (shift partial remainder, trial-subtract divisor, set quotient bit).
- MUL/DIV exit: after the step where counter==0 (edge DATA_WIDTH), go to FIX.
- FIX (edge DATA_WIDTH+1):
  - Apply sign correction: product negated if signs differ; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Write HI (product high half / remainder) and LO (product low half / quotient).
  - o_done <= 1; go to IDLE.
  - Total latency: result visible in the cycle after edge DATA_WIDTH+1 (edge 33 for default).
- o_done deasserts at the next edge.
- o_busy is combinational from state; it is 1 in the cycles after edges 0..DATA_WIDTH.
- o_stall = o_busy & i_start & (i_funct_code is any of the eight codes above). It is combinational and deasserts in the o_done cycle, so a stalled MFHI reads the new HI in that cycle.
- i_start with a non-MDU code while busy: no stall, no effect.
- Divide by zero (i_data_b=0): runs full latency; LO=all ones, HI=i_data_a as latched (signed: original signed dividend).
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- i_flush while busy: next edge goes to IDLE; HI/LO unchanged; o_done stays 0.
- i_flush in IDLE: blocks acceptance of i_start in the same cycle.
- i_flush has priority over FIX: HI/LO are not written.
- Counter arithmetic wraps modulo 2^CNT_SIZE, but the counter is never decremented below 0 because the exit happens at 0.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> o_busy high 33 cycles; in the o_done cycle HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Issue MFHI while busy -> o_stall=1 every cycle until the o_done cycle; o_read_data then equals the new HI. MTLO 0x1234 in IDLE -> LO=0x1234 after one edge, no stall.
- Start MULT, assert i_flush at cycle 10 -> IDLE next edge, HI/LO keep the prior values, no o_done.
- Deassert i_reset_n at cycle 20 of a DIV -> all outputs 0 immediately, without waiting for a clock edge. After release, a new DIVU completes normally with full latency.
